// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with an internal oversampling baud counter.
// Deserialises start/data/parity/stop frames from the rx pin and presents each word on a
// valid/ready handshake together with parity, framing and overrun indications.
// Optional build macro: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each
// sample point; the decision is then taken one cycle after the nominal sample point.
module uart_rx_param #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam int unsigned MID   = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned START_PT = MID + 1;
`else
   localparam int unsigned START_PT = MID;
`endif
   localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_PT);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic             ODD       = 1'(PARITY_ODD);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t               state;
   logic                 rx_meta;
   logic                 rx_s;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err_r;
   logic                 frm_err_r;
   logic                 wait_high;
   logic                 bit_val;
   logic                 frame_err_next;

   // Two-flop synchroniser for the asynchronous rx pin
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic rx_h1;
   logic rx_h2;

   // History of rx_s so the decision cycle sees the samples at -1, 0 and +1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_h1 <= 1'b1;
         rx_h2 <= 1'b1;
      end else begin
         rx_h1 <= rx_s;
         rx_h2 <= rx_h1;
      end
   end

   assign bit_val = (rx_s & rx_h1) | (rx_s & rx_h2) | (rx_h1 & rx_h2);
`else
   assign bit_val = rx_s;
`endif

   // A low stop sample anywhere in the stop field marks the frame as broken
   assign frame_err_next = frm_err_r | ~bit_val;

   // Receive FSM, baud counter and output handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         shreg      <= '0;
         par_err_r  <= 1'b0;
         frm_err_r  <= 1'b0;
         wait_high  <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         overrun <= 1'b0;

         // Consumer takes the word; a delivery below in the same cycle overrides this
         if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (wait_high) begin
                  if (rx_s) wait_high <= 1'b0;
               end else if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end

            START: begin
               if (cnt == START_CNT) begin
                  cnt <= '0;
                  if (bit_val) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state     <= DATA;
                     bit_idx   <= '0;
                     par_err_r <= 1'b0;
                     frm_err_r <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == LAST_CNT) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= bit_val;
                  if (bit_idx == LAST_IDX) begin
                     state    <= (PARITY_EN != 0) ? PARITY : STOP;
                     stop_idx <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            PARITY: begin
               if (cnt == LAST_CNT) begin
                  cnt       <= '0;
                  par_err_r <= ((^shreg) ^ bit_val) != ODD;
                  state     <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (stop_idx == LAST_STOP) begin
                     // Deliver without waiting for the end of the stop bit
                     if (!rx_valid || rx_ready) begin
                        rx_data    <= shreg;
                        parity_err <= par_err_r;
                        frame_err  <= frame_err_next;
                        rx_valid   <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     state     <= IDLE;
                     busy      <= 1'b0;
                     wait_high <= frame_err_next;
                  end else begin
                     frm_err_r <= frame_err_next;
                     stop_idx  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are serialised from a byte-level model,
// expected words are queued at send time and a monitor compares every accepted word.
module tb_uart_rx_param;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned CPB        = 16;
   localparam int unsigned PARITY_EN  = 1;
   localparam int unsigned PARITY_ODD = 0;
   localparam int unsigned STOP_BITS  = 1;
   localparam int unsigned MID        = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned MAJ = 1;
`else
   localparam int unsigned MAJ = 0;
`endif
   // Pin edge -> rx_valid: 2 sync + 1 idle detect + MID, then one bit period per remaining bit, +1 load
   localparam int unsigned LAT = 4 + MID + CPB * (DATA_BITS + PARITY_EN + STOP_BITS) + MAJ;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 rx;
   logic                 rx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;
   logic                 busy;

   int checks  = 0;
   int errors  = 0;
   int ovr_cnt = 0;
   logic [DATA_BITS+1:0] exp_q[$];

   uart_rx_param #(
      .DATA_BITS(DATA_BITS), .CLKS_PER_BIT(CPB), .PARITY_EN(PARITY_EN),
      .PARITY_ODD(PARITY_ODD), .STOP_BITS(STOP_BITS)
   ) dut (
      .clk(clk), .reset(reset), .rx(rx), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic expect_word(input logic [DATA_BITS-1:0] d, input logic perr, input logic ferr);
      exp_q.push_back({d, perr, ferr});
   endtask

   // Monitor: every accepted word is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (!reset) begin
         if (overrun) ovr_cnt++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got data 0x%0h perr %0b ferr %0b, none expected",
                        rx_data, parity_err, frame_err);
            end else begin
               check("word", 32'({rx_data, parity_err, frame_err}), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // One bit period on the line; optional 1-cycle inversion at the sample point
   task automatic drive_bit(input logic b, input bit glitch);
      rx = b;
      if (glitch) begin
         repeat (MID) @(posedge clk);
         #1 rx = ~b;
         @(posedge clk);
         #1 rx = b;
         repeat (CPB - MID - 1) @(posedge clk);
         #1;
      end else begin
         repeat (CPB) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int nbits);
      rx = 1'b1;
      repeat (nbits * CPB) @(posedge clk);
      #1;
   endtask

   // glitch: 0 = start bit, 1..DATA_BITS = data bit, -1 = none
   task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit pflip,
                             input logic stop_val, input int glitch);
      logic p;
      drive_bit(1'b0, glitch == 0);
      for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i], glitch == i + 1);
      if (PARITY_EN != 0) begin
         p = (^d) ^ 1'(PARITY_ODD) ^ pflip;
         drive_bit(p, 1'b0);
      end
      for (int i = 0; i < STOP_BITS; i++) drive_bit(stop_val, 1'b0);
   endtask

   initial begin
      int lat;
      int ovr0;
      logic [DATA_BITS-1:0] d;
      bit pf;
      bit sb;

      reset    = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 32'(rx_valid), 0);
      check("reset_data", 32'(rx_data), 0);
      check("reset_flags", 32'({parity_err, frame_err, overrun, busy}), 0);
      reset = 1'b0;
      idle(2);

      // 1: clean frame, latency from pin edge to rx_valid
      expect_word(8'hA5, 1'b0, 1'b0);
      fork
         send_frame(8'hA5, 1'b0, 1'b1, -1);
         begin
            lat = 0;
            do begin
               @(posedge clk);
               #1;
               lat++;
            end while (!rx_valid && lat < 400);
         end
      join
      check("t1_latency", 32'(lat), 32'(LAT));
      idle(1);

      // 2: wrong parity bit
      expect_word(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1, -1);
      idle(1);

      // 3: stop bit low then line held low (break)
      expect_word(8'h81, 1'b0, 1'b1);
      send_frame(8'h81, 1'b0, 1'b0, -1);
      repeat (40 * CPB) @(posedge clk);
      #1;
      check("t3_busy_in_break", 32'(busy), 0);
      check("t3_words_pending", 32'(exp_q.size()), 0);
      idle(2);

      // 4: consumer stalled, second back-to-back frame overruns
      rx_ready = 1'b0;
      ovr0 = ovr_cnt;
      expect_word(8'h11, 1'b0, 1'b0);
      send_frame(8'h11, 1'b0, 1'b1, -1);
      send_frame(8'h22, 1'b0, 1'b1, -1);
      idle(2);
      check("t4_overrun_cycles", 32'(ovr_cnt - ovr0), 1);
      check("t4_data_kept", 32'(rx_data), 32'h11);
      check("t4_valid_held", 32'(rx_valid), 1);
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_valid_drop", 32'(rx_valid), 0);
      idle(1);

      // 5: short low pulse is a false start
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t5_busy_rise", 32'(busy), 1);
      repeat (2) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("t5_busy_fall", 32'(busy), 0);
      check("t5_no_valid", 32'(rx_valid), 0);
      idle(1);

      // 6: reset in the middle of data bit 4 with a word pending
      rx_ready = 1'b0;
      send_frame(8'hC3, 1'b0, 1'b1, -1);
      idle(1);
      check("t6_pending_valid", 32'(rx_valid), 1);
      check("t6_pending_data", 32'(rx_data), 32'hC3);
      drive_bit(1'b0, 1'b0);
      d = 8'h5A;
      for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
      rx = d[4];
      repeat (MID) @(posedge clk);
      #3 reset = 1'b1;
      rx = 1'b1;
      #1;
      check("t6_reset_valid", 32'(rx_valid), 0);
      check("t6_reset_data", 32'(rx_data), 0);
      check("t6_reset_flags", 32'({parity_err, frame_err, overrun, busy}), 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      rx_ready = 1'b1;
      idle(2);
      expect_word(8'h5A, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1, -1);
      idle(1);

`ifdef UART_RX_MAJORITY_EN
      // Single-cycle glitches at sample points are voted out
      expect_word(8'h96, 1'b0, 1'b0);
      send_frame(8'h96, 1'b0, 1'b1, 3);
      expect_word(8'h0F, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b0, 1'b1, 0);
      idle(1);
`endif

      // Random frames with occasional parity and stop errors, consumer always ready
      for (int n = 0; n < 24; n++) begin
         d  = DATA_BITS'($urandom);
         pf = ($urandom_range(3) == 0);
         sb = ($urandom_range(4) == 0);
         expect_word(d, pf, sb);
         send_frame(d, pf, ~sb, -1);
         if (sb) idle(1 + $urandom_range(1));
         else if ($urandom_range(2) != 0) idle($urandom_range(2));
      end
      idle(2);
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
